// File: rtl/tlb_fill.sv
// tlb_fill: hardware page-table walker that fills an 8-entry TLB register file.
//
// On a one-cycle miss request it reads one word from a linear page table.
// If the page is present, it installs the translation into the register file.
// If the page is absent, it signals a fault. Either way it ends with a
// single-cycle miss_done pulse.
//
// Ports
//   clk          clock, rising-edge active
//   rst          asynchronous active-high reset
//   miss_req     one-cycle fill request for miss_va (honoured only when idle)
//   miss_va      faulting virtual address, VPN = miss_va[31:12]
//   flush        clears every valid bit and the replacement pointer
//   busy         FSM is not idle
//   miss_done    one-cycle completion pulse
//   miss_fault   qualifies miss_done: the page was not present
//   mem_req      page-table read request, held until mem_rdy
//   mem_addr     page-table word address
//   mem_rdy      read accepted; mem_rd_data valid in the same cycle
//   mem_rd_data  page-table word: [0] r/w, [1] present, [2] cacheable, [31:12] PPN
//   tlb_reg_out  packed entries, entry i at [i*PTE_WIDTH +: PTE_WIDTH]
//
// Entry format: [0] r/w, [1] present, [2] valid, [22:3] PPN, [42:23] VPN,
// [43] cacheable.
module tlb_fill #(
    parameter int          PTE_WIDTH = 44,
    parameter logic [31:0] PT_BASE   = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss_req,
    input  logic [31:0]            miss_va,
    input  logic                   flush,
    output logic                   busy,
    output logic                   miss_done,
    output logic                   miss_fault,
    output logic                   mem_req,
    output logic [31:0]            mem_addr,
    input  logic                   mem_rdy,
    input  logic [31:0]            mem_rd_data,
    output logic [PTE_WIDTH*8-1:0] tlb_reg_out
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        INSTALL = 3'd2,
        DONE    = 3'd3,
        FAULT   = 3'd4
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [19:0]          vpn_r;
    logic [19:0]          ppn_r;
    logic                 rw_r;
    logic                 present_r;
    logic                 cacheable_r;
    logic [2:0]           rr_ptr_r;
    logic [PTE_WIDTH-1:0] entry_r [8];

    logic                 hit_s;
    logic [2:0]           hit_idx_s;
    logic                 free_s;
    logic [2:0]           free_idx_s;
    logic [2:0]           target_s;
    logic                 use_rr_s;
    logic                 unused_s;

    // Assemble a valid TLB entry from the latched page-table fields.
    function automatic logic [PTE_WIDTH-1:0] make_entry(
        input logic        cacheable,
        input logic [19:0] vpn,
        input logic [19:0] ppn,
        input logic        present,
        input logic        rw
    );
        logic [PTE_WIDTH-1:0] e;
        e        = '0;
        e[0]     = rw;
        e[1]     = present;
        e[2]     = 1'b1;
        e[22:3]  = ppn;
        e[42:23] = vpn;
        e[43]    = cacheable;
        return e;
    endfunction

    // Page-offset bits and unused page-table attribute bits carry no information here.
    assign unused_s = ^{miss_va[11:0], mem_rd_data[11:3]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; flush deliberately has no influence on the sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = miss_req ? REQ : IDLE;
            REQ: begin
                if (mem_rdy) begin
                    state_next_s = mem_rd_data[1] ? INSTALL : FAULT;
                end else begin
                    state_next_s = REQ;
                end
            end
            INSTALL: state_next_s = DONE;
            DONE:    state_next_s = IDLE;
            FAULT:   state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Status and memory-request outputs are pure decodes of the state register.
    always_comb begin
        busy       = (state_r != IDLE);
        mem_req    = (state_r == REQ);
        miss_done  = (state_r == DONE) || (state_r == FAULT);
        miss_fault = (state_r == FAULT);
        mem_addr   = PT_BASE + {10'b0, vpn_r, 2'b00};
    end

    // Target selection: an existing hit is reused so a VPN never appears twice,
    // then the lowest free slot, then the round-robin victim. The loop runs
    // downward so the lowest matching index is the one that survives.
    always_comb begin
        hit_s      = 1'b0;
        hit_idx_s  = 3'd0;
        free_s     = 1'b0;
        free_idx_s = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            hit_idx_s  = (entry_r[i][2] && (entry_r[i][42:23] == vpn_r)) ? 3'(i) : hit_idx_s;
            hit_s      = hit_s | (entry_r[i][2] && (entry_r[i][42:23] == vpn_r));
            free_idx_s = (!entry_r[i][2]) ? 3'(i) : free_idx_s;
            free_s     = free_s | !entry_r[i][2];
        end
        target_s = hit_s ? hit_idx_s : (free_s ? free_idx_s : rr_ptr_r);
        use_rr_s = !hit_s && !free_s;
    end

    // Request latches, page-table word capture, entry install and flush.
    // Flush takes priority over an install in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpn_r       <= 20'd0;
            ppn_r       <= 20'd0;
            rw_r        <= 1'b0;
            present_r   <= 1'b0;
            cacheable_r <= 1'b0;
            rr_ptr_r    <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                entry_r[i] <= '0;
            end
        end else begin
            if (state_r == IDLE && miss_req) begin
                vpn_r <= miss_va[31:12];
            end
            if (state_r == REQ && mem_rdy) begin
                ppn_r       <= mem_rd_data[31:12];
                cacheable_r <= mem_rd_data[2];
                present_r   <= mem_rd_data[1];
                rw_r        <= mem_rd_data[0];
            end
            if (flush) begin
                for (int i = 0; i < 8; i++) begin
                    entry_r[i][2] <= 1'b0;
                end
                rr_ptr_r <= 3'd0;
            end else if (state_r == INSTALL) begin
                entry_r[target_s] <= make_entry(cacheable_r, vpn_r, ppn_r, present_r, rw_r);
                if (use_rr_s) begin
                    rr_ptr_r <= rr_ptr_r + 3'd1;
                end
            end
        end
    end

    // Register file exposed directly, no input-to-output path.
    for (genvar g = 0; g < 8; g++) begin : g_out
        assign tlb_reg_out[g*PTE_WIDTH +: PTE_WIDTH] = entry_r[g];
    end

endmodule

// File: tb/tb_tlb_fill.sv
module tb_tlb_fill;

    localparam int          PW     = 44;
    localparam int          IW     = PW * 8;
    localparam logic [31:0] PTBASE = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          miss_req = 1'b0;
    logic [31:0]   miss_va = 32'd0;
    logic          flush = 1'b0;
    logic          busy, miss_done, miss_fault, mem_req;
    logic [31:0]   mem_addr;
    logic          mem_rdy = 1'b0;
    logic [31:0]   mem_rd_data = 32'd0;
    logic [IW-1:0] tlb_reg_out;

    tlb_fill #(.PTE_WIDTH(PW), .PT_BASE(PTBASE)) dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_va(miss_va), .flush(flush),
        .busy(busy), .miss_done(miss_done), .miss_fault(miss_fault), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_rd_data(mem_rd_data),
        .tlb_reg_out(tlb_reg_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference TLB model: eight slots with fields and a replacement counter.
    logic        m_v   [8];
    logic [19:0] m_vpn [8];
    logic [19:0] m_ppn [8];
    logic        m_rw  [8];
    logic        m_p   [8];
    logic        m_c   [8];
    int          m_rr;

    function automatic logic [IW-1:0] image();
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            r[i*PW +: PW] = {m_c[i], m_vpn[i], m_ppn[i], m_v[i], m_p[i], m_rw[i]};
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_v[i] = 1'b0; m_vpn[i] = 20'd0; m_ppn[i] = 20'd0;
            m_rw[i] = 1'b0; m_p[i] = 1'b0; m_c[i] = 1'b0;
        end
        m_rr = 0;
    endtask

    task automatic model_flush();
        for (int i = 0; i < 8; i++) m_v[i] = 1'b0;
        m_rr = 0;
    endtask

    task automatic model_fill(input logic [19:0] vpn, input logic [31:0] d);
        int t;
        t = -1;
        for (int i = 0; i < 8; i++) if (t < 0 && m_v[i] && m_vpn[i] == vpn) t = i;
        for (int i = 0; i < 8; i++) if (t < 0 && !m_v[i]) t = i;
        if (t < 0) begin
            t = m_rr;
            m_rr = (m_rr + 1) % 8;
        end
        m_v[t] = 1'b1; m_vpn[t] = vpn; m_ppn[t] = d[31:12];
        m_rw[t] = d[0]; m_p[t] = d[1]; m_c[t] = d[2];
    endtask

    typedef struct {
        logic          fault;
        logic [IW-1:0] img;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    // Monitor: each completion pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && miss_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_fault", miss_fault, e.fault);
                chk("done_image", tlb_reg_out, e.img);
                chk("done_cycle", cyc, e.cyc);
                chk("done_busy", busy, 1'b1);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic do_miss(input logic [31:0] va, input logic [31:0] d, input int dly,
                           input bit fl, input bit junk);
        exp_t it;
        @(posedge clk); #1;
        miss_req = 1'b1; miss_va = va;
        @(posedge clk); #1;
        miss_req = junk; miss_va = $urandom;
        chk("mem_req_on", mem_req, 1'b1);
        chk("mem_addr", mem_addr, PTBASE + {10'b0, va[31:12], 2'b00});
        for (int k = 0; k < dly; k++) begin
            @(posedge clk); #1;
            miss_req = 1'b0;
            chk("mem_req_held", mem_req, 1'b1);
        end
        mem_rd_data = d; mem_rdy = 1'b1;
        it.cyc = cyc + (d[1] ? 2 : 1);
        if (d[1]) begin
            if (fl) model_flush();
            else    model_fill(va[31:12], d);
        end
        it.fault = !d[1];
        it.img   = image();
        sb.push_back(it);
        @(posedge clk); #1;
        mem_rdy = 1'b0; miss_req = 1'b0; mem_rd_data = $urandom;
        chk("mem_req_off", mem_req, 1'b0);
        flush = fl && d[1];
        @(posedge clk); #1;
        flush = 1'b0;
        wait_idle();
    endtask

    task automatic idle_flush();
        @(posedge clk); #1;
        flush = 1'b1;
        model_flush();
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pool [12];
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tlb", tlb_reg_out, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_done", miss_done, 1'b0);
        rst = 1'b0;

        // Basic fill and fault.
        do_miss(32'h0000_2ABC, 32'h0000_5007, 0, 1'b0, 1'b0);
        chk("basic_entry0", tlb_reg_out[PW-1:0], {1'b1, 20'h00002, 20'h00005, 3'b111});
        do_miss(32'h0000_7000, 32'h0000_5005, 2, 1'b0, 1'b1);

        // Replacement: eight distinct, then ninth and tenth go round-robin.
        idle_flush();
        for (int i = 0; i < 10; i++)
            do_miss({20'h00100 + 20'(i), 12'h000}, {20'h00A00 + 20'(i), 12'h003}, i % 3, 1'b0, 1'b0);
        chk("rr_entry0_vpn", tlb_reg_out[0*PW+23 +: 20], 20'h00108);
        chk("rr_entry1_vpn", tlb_reg_out[1*PW+23 +: 20], 20'h00109);

        // Duplicate VPN overwrites the existing slot.
        do_miss(32'h0010_3000, 32'h0007_7003, 1, 1'b0, 1'b0);
        chk("dup_entry3_ppn", tlb_reg_out[3*PW+3 +: 20], 20'h00077);

        // Flush during install, then the next fill lands in slot 0.
        do_miss(32'h0020_0000, 32'h0001_1007, 0, 1'b1, 1'b0);
        do_miss(32'h0020_1000, 32'h0001_2003, 0, 1'b0, 1'b0);
        chk("post_flush_entry0_vpn", tlb_reg_out[0*PW+23 +: 20], 20'h00201);

        // Randomized traffic over a small VPN pool so hits and evictions recur.
        for (int i = 0; i < 12; i++) pool[i] = {$urandom_range(0, 20'hFFFFF), 12'(i)};
        for (int n = 0; n < 80; n++) begin
            logic [31:0] d;
            d = $urandom;
            d[1] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) idle_flush();
            if ($urandom_range(0, 9) == 0) begin
                @(posedge clk); #1;
                mem_rdy = 1'b1; mem_rd_data = 32'h0000_5007;
                @(posedge clk); #1;
                mem_rdy = 1'b0;
                chk("stray_rdy_busy", busy, 1'b0);
            end
            do_miss(pool[$urandom_range(0, 11)], d, $urandom_range(0, 3),
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1);
        end

        // Reset in the middle of a request.
        @(posedge clk); #1;
        miss_req = 1'b1; miss_va = 32'h1234_5000;
        @(posedge clk); #1;
        miss_req = 1'b0;
        chk("pre_rst_mem_req", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_mem_req", mem_req, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_tlb", tlb_reg_out, '0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rdy = 1'b1; mem_rd_data = 32'h0000_5007;
        @(posedge clk); #1;
        mem_rdy = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_tlb", tlb_reg_out, '0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
